// File: rtl/control_nivel_pkg.sv
// Shared constants for the vehicle-level blocks: FSM state encodings,
// level codes and the default shift periods per level.
package control_nivel_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RUN  = 3'd1,
    ST_NEXT = 3'd2,
    ST_OVER = 3'd3,
    ST_DONE = 3'd4
  } cnv_state_t;

  localparam int NV_1 = 0;
  localparam int NV_2 = 1;
  localparam int NV_3 = 2;
  localparam int NV_4 = 3;

  localparam int PERIOD_NV_1_DEF = 12000000;
  localparam int PERIOD_NV_2_DEF = 9000000;
  localparam int PERIOD_NV_3_DEF = 6000000;
  localparam int PERIOD_NV_4_DEF = 3000000;

  // Codes above NV_4 never occur; they fall back to the fastest period.
  function automatic int level_period(input int lvl, input int p1, input int p2,
                                      input int p3, input int p4);
    case (lvl)
      NV_1:    return p1;
      NV_2:    return p2;
      NV_3:    return p3;
      default: return p4;
    endcase
  endfunction

endpackage

// File: rtl/control_nivel_prescaler.sv
// Shift-tick prescaler: counts 0..period-1 while enabled and flags the
// terminal count combinationally in that same cycle.
module cnv_prescaler #(
  parameter int WIDTH = 24
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             enable,
  input  logic [WIDTH-1:0] period,
  output logic [WIDTH-1:0] count,
  output logic             tc
);

  // The pulse survives a same-cycle clear so a coincident win/collision
  // does not swallow the shift that was already due.
  assign tc = enable && (count == (period - WIDTH'(1)));

  always_ff @(posedge clk) begin
    if (clear) begin
      count <= '0;
    end else if (enable) begin
      if (tc) count <= '0;
      else    count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/control_nivel.sv
// Game level sequencer: paces lane shifts per level and tracks win/lose.
// Optional freeze input enabled by defining CNV_PAUSE_EN.
//
// state | meaning
// IDLE  | after reset, waiting for START
// RUN   | level active, lane shifts paced by the prescaler
// NEXT  | one-cycle gap after a cleared level, level code already advanced
// OVER  | frog hit a vehicle, waiting for START
// DONE  | last level cleared, waiting for START
module control_nivel
  import control_nivel_pkg::*;
#(
  parameter int DATAWIDTH_NVL = 2,
  parameter int DATAWIDTH_DIV = 24,
  parameter int PERIOD_NV_1   = PERIOD_NV_1_DEF,
  parameter int PERIOD_NV_2   = PERIOD_NV_2_DEF,
  parameter int PERIOD_NV_3   = PERIOD_NV_3_DEF,
  parameter int PERIOD_NV_4   = PERIOD_NV_4_DEF
) (
  input  logic                     CNV_CLOCK,
  input  logic                     CNV_RESET,
  input  logic                     CNV_START_IN,
  input  logic                     CNV_WIN_IN,
  input  logic                     CNV_COLLISION_IN,
`ifdef CNV_PAUSE_EN
  input  logic                     CNV_PAUSE_IN,
`endif
  output logic [DATAWIDTH_NVL-1:0] CNV_NVL_OUT,
  output logic                     CNV_CN_OUT,
  output logic                     CNV_RUN_OUT,
  output logic                     CNV_GAMEOVER_OUT,
  output logic                     CNV_DONE_OUT
);

  cnv_state_t               state;
  logic [DATAWIDTH_NVL-1:0] nvl;
  logic [DATAWIDTH_DIV-1:0] period;
  logic [DATAWIDTH_DIV-1:0] count_unused;
  logic                     in_run;
  logic                     presc_clear;
  logic                     presc_enable;
  logic                     presc_tc;

  assign in_run = (state == ST_RUN);
  assign period = DATAWIDTH_DIV'(level_period(int'(nvl), PERIOD_NV_1, PERIOD_NV_2,
                                              PERIOD_NV_3, PERIOD_NV_4));

  // Any exit from RUN, and reset itself, leaves the prescaler at zero so the
  // next RUN entry always starts a full period.
  assign presc_clear = !CNV_RESET || !in_run || CNV_WIN_IN || CNV_COLLISION_IN;

  // Gating with reset drops a tick that would land in the reset cycle.
`ifdef CNV_PAUSE_EN
  assign presc_enable = in_run && CNV_RESET && !CNV_PAUSE_IN;
`else
  assign presc_enable = in_run && CNV_RESET;
`endif

  cnv_prescaler #(
    .WIDTH (DATAWIDTH_DIV)
  ) u_prescaler (
    .clk    (CNV_CLOCK),
    .clear  (presc_clear),
    .enable (presc_enable),
    .period (period),
    .count  (count_unused),
    .tc     (presc_tc)
  );

  assign CNV_CN_OUT  = presc_tc;
  assign CNV_NVL_OUT = nvl;

  always_ff @(posedge CNV_CLOCK) begin
    if (!CNV_RESET) begin
      state            <= ST_IDLE;
      nvl              <= '0;
      CNV_RUN_OUT      <= 1'b0;
      CNV_GAMEOVER_OUT <= 1'b0;
      CNV_DONE_OUT     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_OVER, ST_DONE: begin
          if (CNV_START_IN) begin
            state            <= ST_RUN;
            nvl              <= '0;
            CNV_RUN_OUT      <= 1'b1;
            CNV_GAMEOVER_OUT <= 1'b0;
            CNV_DONE_OUT     <= 1'b0;
          end
        end
        ST_RUN: begin
          // Collision wins over a simultaneous win.
          if (CNV_COLLISION_IN) begin
            state            <= ST_OVER;
            CNV_RUN_OUT      <= 1'b0;
            CNV_GAMEOVER_OUT <= 1'b1;
          end else if (CNV_WIN_IN) begin
            CNV_RUN_OUT <= 1'b0;
            if (nvl == DATAWIDTH_NVL'(NV_4)) begin
              state        <= ST_DONE;
              CNV_DONE_OUT <= 1'b1;
            end else begin
              state <= ST_NEXT;
              nvl   <= nvl + DATAWIDTH_NVL'(1);
            end
          end
        end
        ST_NEXT: begin
          state       <= ST_RUN;
          CNV_RUN_OUT <= 1'b1;
        end
        default: begin
          state            <= ST_IDLE;
          nvl              <= '0;
          CNV_RUN_OUT      <= 1'b0;
          CNV_GAMEOVER_OUT <= 1'b0;
          CNV_DONE_OUT     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_control_nivel.sv
// Directed bench for control_nivel with short periods (4,3,2,2); a reference
// model feeds a scoreboard of expected outputs checked every cycle.
module tb_control_nivel;

  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_NEXT = 2;
  localparam int M_OVER = 3;
  localparam int M_DONE = 4;

  typedef struct {
    string      tag;
    logic [1:0] nvl;
    logic       cn;
    logic       run;
    logic       over;
    logic       done;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       start;
  logic       win;
  logic       col;
  logic       pause;
  logic [1:0] nvl;
  logic       cn;
  logic       run;
  logic       over;
  logic       done;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   m_state = M_IDLE;
  int   m_nvl = 0;
  int   m_cnt = 0;
  logic       last_cn;
  logic [1:0] last_nvl;
  logic       last_run;
  logic       last_over;
  logic       last_done;

  control_nivel #(
    .DATAWIDTH_NVL (2),
    .DATAWIDTH_DIV (24),
    .PERIOD_NV_1   (4),
    .PERIOD_NV_2   (3),
    .PERIOD_NV_3   (2),
    .PERIOD_NV_4   (2)
  ) dut (
    .CNV_CLOCK        (clk),
    .CNV_RESET        (rst),
    .CNV_START_IN     (start),
    .CNV_WIN_IN       (win),
    .CNV_COLLISION_IN (col),
`ifdef CNV_PAUSE_EN
    .CNV_PAUSE_IN     (pause),
`endif
    .CNV_NVL_OUT      (nvl),
    .CNV_CN_OUT       (cn),
    .CNV_RUN_OUT      (run),
    .CNV_GAMEOVER_OUT (over),
    .CNV_DONE_OUT     (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int per(input int lvl);
    case (lvl)
      0:       return 4;
      1:       return 3;
      default: return 2;
    endcase
  endfunction

  task automatic cmp(input string tag, input logic [1:0] obs, input logic [1:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // One clock cycle: drive inputs, queue the model's expectation, compare
  // mid-cycle, then advance the model on the rising edge.
  task automatic step(input logic s, input logic w, input logic c, input logic r,
                      input logic p, input string tag);
    exp_t e;
    start = s; win = w; col = c; rst = r; pause = p;
    e.tag  = tag;
    e.nvl  = 2'(m_nvl);
    e.cn   = (m_state == M_RUN) && r && !p && (m_cnt == per(m_nvl) - 1);
    e.run  = (m_state == M_RUN);
    e.over = (m_state == M_OVER);
    e.done = (m_state == M_DONE);
    sb.push_back(e);
    @(negedge clk);
    e = sb.pop_front();
    cmp({e.tag, ".nvl"},  nvl,  e.nvl);
    cmp({e.tag, ".cn"},   {1'b0, cn},   {1'b0, e.cn});
    cmp({e.tag, ".run"},  {1'b0, run},  {1'b0, e.run});
    cmp({e.tag, ".over"}, {1'b0, over}, {1'b0, e.over});
    cmp({e.tag, ".done"}, {1'b0, done}, {1'b0, e.done});
    last_cn = cn; last_nvl = nvl; last_run = run; last_over = over; last_done = done;
    @(posedge clk);
    if (!r) begin
      m_state = M_IDLE; m_nvl = 0; m_cnt = 0;
    end else begin
      case (m_state)
        M_RUN: begin
          if (c) begin
            m_state = M_OVER; m_cnt = 0;
          end else if (w) begin
            m_cnt = 0;
            if (m_nvl < 3) begin
              m_state = M_NEXT; m_nvl++;
            end else begin
              m_state = M_DONE;
            end
          end else if (!p) begin
            m_cnt = (m_cnt == per(m_nvl) - 1) ? 0 : m_cnt + 1;
          end
        end
        M_NEXT: begin
          m_state = M_RUN; m_cnt = 0;
        end
        default: begin
          if (s) begin
            m_state = M_RUN; m_nvl = 0; m_cnt = 0;
          end
        end
      endcase
    end
    #1;
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; win = 1'b0; col = 1'b0; pause = 1'b0;
    @(posedge clk);
    #1;

    // reset overrides START
    step(1, 0, 0, 0, 0, "rst_a");
    step(1, 0, 0, 0, 0, "rst_b");
    cmp("rst_run", {1'b0, last_run}, 2'd0);
    step(0, 0, 0, 1, 0, "idle");

    // START at t=0, shifts at t=4,8,12 on level 0
    step(1, 0, 0, 1, 0, "start");
    for (int t = 1; t <= 13; t++) begin
      step(0, 0, 0, 1, 0, "run0");
      if (t == 1) cmp("run_t1", {1'b0, last_run}, 2'd1);
      if (t == 4 || t == 8 || t == 12) cmp("cn_pulse", {1'b0, last_cn}, 2'd1);
      else cmp("cn_quiet", {1'b0, last_cn}, 2'd0);
    end

    // win at level 0: one NEXT cycle, then period 3
    step(0, 1, 0, 1, 0, "win0");
    step(0, 0, 0, 1, 0, "next1");
    cmp("next_nvl", last_nvl, 2'd1);
    cmp("next_run", {1'b0, last_run}, 2'd0);
    step(0, 0, 0, 1, 0, "r1a");
    step(0, 0, 0, 1, 0, "r1b");
    cmp("r1b_cn", {1'b0, last_cn}, 2'd0);
    step(0, 0, 0, 1, 0, "r1c");
    cmp("r1c_cn", {1'b0, last_cn}, 2'd1);

    // climb to level 3; level 2 win coincides with a terminal count
    step(0, 1, 0, 1, 0, "win1");
    step(0, 0, 0, 1, 0, "next2");
    step(0, 0, 0, 1, 0, "r2a");
    step(0, 1, 0, 1, 0, "win2_tc");
    cmp("win_tc_cn", {1'b0, last_cn}, 2'd1);
    step(0, 0, 0, 1, 0, "next3");
    step(0, 0, 0, 1, 0, "r3a");
    step(0, 1, 0, 1, 0, "win3");
    step(0, 0, 0, 1, 0, "done_a");
    cmp("done_flag", {1'b0, last_done}, 2'd1);
    cmp("done_nvl", last_nvl, 2'd3);
    step(0, 1, 0, 1, 0, "done_hold");
    step(1, 0, 0, 1, 0, "done_start");
    step(0, 0, 0, 1, 0, "restart");
    cmp("restart_nvl", last_nvl, 2'd0);

    // simultaneous win and collision at level 1 -> game over
    step(0, 1, 0, 1, 0, "win_l0");
    step(0, 0, 0, 1, 0, "next_l1");
    step(0, 0, 0, 1, 0, "r_l1");
    step(0, 1, 1, 1, 0, "win_col");
    for (int i = 0; i < 4; i++) begin
      step(0, i[0], ~i[0], 1, 0, "over_hold");
      cmp("over_cn", {1'b0, last_cn}, 2'd0);
    end
    cmp("over_nvl", last_nvl, 2'd1);
    step(1, 0, 0, 1, 0, "over_start");

    // START ignored while running
    for (int i = 0; i < 4; i++) step(1, 0, 0, 1, 0, "start_in_run");
    cmp("no_restart_cn", {1'b0, last_cn}, 2'd1);

    // reset mid-run at level 2 with prescaler=1 drops the due tick
    step(0, 1, 0, 1, 0, "rw0");
    step(0, 0, 0, 1, 0, "rn1");
    step(0, 0, 0, 1, 0, "rr1");
    step(0, 1, 0, 1, 0, "rw1");
    step(0, 0, 0, 1, 0, "rn2");
    step(0, 0, 0, 1, 0, "rr2");
    step(1, 0, 0, 0, 0, "mid_rst");
    cmp("mid_rst_cn", {1'b0, last_cn}, 2'd0);
    step(1, 0, 0, 0, 0, "rst_hold");
    cmp("rst_hold_run", {1'b0, last_run}, 2'd0);
    step(0, 0, 0, 1, 0, "rst_rel");
    cmp("rel_cn", {1'b0, last_cn}, 2'd0);
    step(1, 0, 0, 1, 0, "start2");
    step(0, 0, 0, 1, 0, "run2");
    cmp("run2_run", {1'b0, last_run}, 2'd1);

`ifdef CNV_PAUSE_EN
    // pause at prescaler=2 on level 0 for 5 cycles
    step(0, 0, 0, 1, 0, "pre_pause");
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 0, 1, 1, "paused");
      cmp("pause_cn", {1'b0, last_cn}, 2'd0);
    end
    step(0, 0, 0, 1, 0, "unpause_a");
    cmp("unpause_a_cn", {1'b0, last_cn}, 2'd0);
    step(0, 0, 0, 1, 0, "unpause_b");
    cmp("unpause_b_cn", {1'b0, last_cn}, 2'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/control_nivel.md
CONTROL_NIVEL -- requirements
Module: control_nivel

Interface
REQ-001 SHALL provide parameter DATAWIDTH_NVL, default 2, width of the level code.
REQ-002 SHALL provide parameter DATAWIDTH_DIV, default 24, width of the shift-tick prescaler counter.
REQ-003 SHALL provide parameters PERIOD_NV_1/2/3/4, defaults 12000000/9000000/6000000/3000000, clock cycles between lane shifts per level.
REQ-004 SHALL have one clock; reset is synchronous and active-low.
REQ-005 SHALL have these ports:
- CNV_CLOCK  in  1  clock, rising edge.
- CNV_RESET  in  1  synchronous active-low reset.
- CNV_START_IN  in  1  start/restart request, level-sampled.
- CNV_WIN_IN  in  1  one-cycle pulse, frog crossed all lanes.
- CNV_COLLISION_IN  in  1  one-cycle pulse, frog hit vehicle.
- CNV_PAUSE_IN  in  1  freeze request; present only with CNV_PAUSE_EN.
- CNV_NVL_OUT  out  DATAWIDTH_NVL  level code to vehicle-lane registers.
- CNV_CN_OUT  out  1  one-cycle lane-shift pulse to vehicle-lane registers.
- CNV_RUN_OUT  out  1  high while in RUN.
- CNV_GAMEOVER_OUT  out  1  high while in OVER.
- CNV_DONE_OUT  out  1  high while in DONE (level 4 cleared).

Function
REQ-006 SHALL implement FSM states IDLE, RUN, NEXT, OVER, DONE, all registered.
REQ-007 IDLE: START=1 -> RUN, NVL=0, prescaler=0.
REQ-008 RUN: prescaler increments each cycle; at PERIOD(NVL)-1 it clears and CN_OUT=1 for that cycle only.
REQ-009 CN_OUT SHALL be 0 in every state other than RUN.
REQ-010 RUN and COLLISION=1 -> OVER; NVL held; prescaler cleared.
REQ-011 RUN, WIN=1, NVL<3 -> NEXT; NVL incremented on the same edge; prescaler cleared.
REQ-012 RUN, WIN=1, NVL=3 -> DONE; NVL held at 3; no wrap-around to 0.
REQ-013 Simultaneous WIN and COLLISION SHALL be treated as COLLISION only.
REQ-014 If WIN or COLLISION coincides with a prescaler terminal count, CN_OUT SHALL still pulse in that cycle.
REQ-015 NEXT SHALL last exactly one cycle, then go to RUN unconditionally; WIN/COLLISION are ignored in NEXT.
REQ-016 OVER and DONE: START=1 -> RUN with NVL=0 and prescaler=0; otherwise hold.
REQ-017 START SHALL be ignored in RUN and NEXT.
REQ-018 Latency: START sampled at edge k gives RUN_OUT=1 after edge k; first CN_OUT pulse in cycle k+PERIOD_NV_1.
REQ-019 PERIOD values SHALL be >=2 and <2^DATAWIDTH_DIV; prescaler compare is unsigned at full DATAWIDTH_DIV width.

Reset
REQ-020 CNV_RESET=0 at a rising edge SHALL force IDLE, NVL_OUT=0, prescaler=0, and CN/RUN/GAMEOVER/DONE outputs=0, overriding all inputs.
REQ-021 Reset asserted mid-RUN SHALL drop any pending CN pulse; no CN pulse is produced in the first cycle after reset release.

Configuration
REQ-022 With macro CNV_PAUSE_EN defined, CNV_PAUSE_IN SHALL exist and PAUSE=1 in RUN freezes the prescaler and forces CN_OUT=0.
REQ-023 With CNV_PAUSE_EN defined, WIN and COLLISION SHALL still be honoured while paused, and NEXT/OVER/DONE SHALL be unaffected by PAUSE.
REQ-024 Without CNV_PAUSE_EN, the CNV_PAUSE_IN port and all pause logic SHALL be absent.

Structure
REQ-025 The state encodings, level codes NV_1..NV_4 (0..3), and default PERIOD constants SHALL reside in a shared constants include used by the vehicle-level blocks.
REQ-026 The prescaler SHALL be a sub-module cnv_prescaler (inputs: clear, enable, period; outputs: count, terminal-count pulse); the FSM stays in control_nivel.

Verification (PERIOD_NV_1..4 = 4,3,2,2)
REQ-027 Reset, then START=1 at cycle 0 -> RUN_OUT=1 from cycle 1; CN_OUT pulses at cycles 4, 8, 12; NVL_OUT=0.
REQ-028 WIN pulse in RUN at NVL=0 -> one NEXT cycle with CN_OUT=0 and NVL_OUT=1; next CN_OUT 3 cycles after RUN re-entry.
REQ-029 Four WIN pulses -> NVL_OUT 1, 2, 3, then DONE_OUT=1 with NVL_OUT=3; START -> RUN with NVL_OUT=0.
REQ-030 WIN and COLLISION in the same cycle at NVL=1 -> GAMEOVER_OUT=1, NVL_OUT=1, CN_OUT stays 0 until START.
REQ-031 CNV_RESET=0 for one cycle mid-RUN at NVL=2, prescaler=1 -> IDLE with all outputs 0; START has no effect until reset is released.
REQ-032 With CNV_PAUSE_EN, PAUSE=1 for 5 cycles at prescaler=2, NVL=0 -> no CN pulse during the pause; CN pulses 2 cycles after PAUSE is released.
